// File: rtl/test_status_dev.sv
//------------------------------------------------------------------------------
// Module   : test_status_dev
// Purpose  : Memory-mapped test-status responder. Software on the core reports
//            failures and end-of-test here. The block keeps a cycle counter and
//            a watchdog timeout, and presents done/passed/timed_out flags for
//            the simulation bench to poll.
// Ports    : clk, rst_n (async, active-low)
//            bus_en/bus_we/bus_addr/bus_wdata : single-cycle bus access
//            bus_rdata/bus_rvalid             : registered read response
//            done/passed/timed_out            : registered run-status flags
//            fail_count                       : live fail counter
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module test_status_dev #(
  parameter logic [31:0] MAX_CYCLES = 32'd100000,
  parameter int          CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 bus_en,
  input  logic                 bus_we,
  input  logic [3:0]           bus_addr,
  input  logic [31:0]          bus_wdata,
  output logic [31:0]          bus_rdata,
  output logic                 bus_rvalid,
  output logic                 done,
  output logic                 passed,
  output logic                 timed_out,
  output logic [CNT_WIDTH-1:0] fail_count
);

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_DONE_PASS = 2'd1,
    ST_DONE_FAIL = 2'd2,
    ST_TIMEOUT   = 2'd3
  } state_t;

  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_FAIL    = 2'd1;
  localparam logic [1:0] REG_CYCLE   = 2'd2;
  localparam logic [1:0] REG_TIMEOUT = 2'd3;

  state_t               state;
  logic [CNT_WIDTH-1:0] cycle_cnt;
  logic [CNT_WIDTH-1:0] fail_cnt;
  logic [CNT_WIDTH-1:0] timeout_reg;

  logic                 wr, rd;
  logic [1:0]           sel;
  logic                 finish, fail_inc, fail_clr, tmo_wr;
  logic [CNT_WIDTH-1:0] fail_next;
  logic [CNT_WIDTH:0]   cycle_plus1;
  logic                 tmo_hit;
  logic [31:0]          rd_mux;

  // Byte-lane bits of the address are don't-care.
  logic unused_addr_bits;
  assign unused_addr_bits = ^bus_addr[1:0];

  always_comb begin
    wr       = bus_en & bus_we;
    rd       = bus_en & ~bus_we;
    sel      = bus_addr[3:2];
    finish   = wr && (sel == REG_CTRL) && bus_wdata[0];
    fail_inc = wr && (sel == REG_CTRL) && bus_wdata[1];
    fail_clr = wr && (sel == REG_FAIL);
    tmo_wr   = wr && (sel == REG_TIMEOUT);

    // Saturating increment; a clear and an increment never share an access.
    fail_next = fail_cnt;
    if (fail_clr)
      fail_next = '0;
    else if (fail_inc && (fail_cnt != '1))
      fail_next = fail_cnt + 1'b1;

    // One extra bit so the compare cannot be fooled by counter wrap.
    cycle_plus1 = {1'b0, cycle_cnt} + 1'b1;
    tmo_hit     = cycle_plus1 >= {1'b0, timeout_reg};

    rd_mux = '0;
    case (sel)
      REG_CTRL:    rd_mux = {28'b0,
                             (state == ST_TIMEOUT),
                             (state == ST_DONE_PASS),
                             (state != ST_RUN),
                             (state == ST_RUN)};
      REG_FAIL:    rd_mux = fail_cnt;
      REG_CYCLE:   rd_mux = cycle_cnt;
      REG_TIMEOUT: rd_mux = timeout_reg;
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_RUN;
      cycle_cnt   <= '0;
      fail_cnt    <= '0;
      timeout_reg <= MAX_CYCLES;
      done        <= 1'b0;
      passed      <= 1'b0;
      timed_out   <= 1'b0;
      bus_rdata   <= '0;
      bus_rvalid  <= 1'b0;
    end else begin
      bus_rvalid <= rd;
      if (rd)
        bus_rdata <= rd_mux;

      // Flags follow the state one cycle later.
      done      <= (state != ST_RUN);
      passed    <= (state == ST_DONE_PASS);
      timed_out <= (state == ST_TIMEOUT);

      if (state == ST_RUN) begin
        cycle_cnt <= cycle_plus1[CNT_WIDTH-1:0];
        fail_cnt  <= fail_next;
        if (tmo_wr)
          timeout_reg <= bus_wdata;
        // FINISH outranks a same-cycle watchdog expiry.
        if (finish)
          state <= (fail_next != '0) ? ST_DONE_FAIL : ST_DONE_PASS;
        else if (tmo_hit)
          state <= ST_TIMEOUT;
      end
    end
  end

  assign fail_count = fail_cnt;

endmodule

`default_nettype wire

// File: tb/tb_test_status_dev.sv
`default_nettype none

module tb_test_status_dev;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bus_en = 1'b0;
  logic        bus_we = 1'b0;
  logic [3:0]  bus_addr = '0;
  logic [31:0] bus_wdata = '0;
  logic [31:0] bus_rdata;
  logic        bus_rvalid;
  logic        done;
  logic        passed;
  logic        timed_out;
  logic [31:0] fail_count;

  int checks = 0;
  int errors = 0;

  test_status_dev dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus_en     (bus_en),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .bus_rvalid (bus_rvalid),
    .done       (done),
    .passed     (passed),
    .timed_out  (timed_out),
    .fail_count (fail_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    bus_en = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
    cyc();
    bus_en = 1'b0; bus_we = 1'b0;
  endtask

  // Request in one cycle, response checked one cycle later.
  task automatic bus_read_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
    bus_en = 1'b1; bus_we = 1'b0; bus_addr = a;
    cyc();
    bus_en = 1'b0;
    chk({tag, "_rvalid"}, {31'b0, bus_rvalid}, 32'd1);
    chk(tag, bus_rdata, exp);
  endtask

  // Assert reset between edges, release on a falling edge.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus_en = 1'b0; bus_we = 1'b0;
    cyc(2);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // ---- 1: clean pass ----
    do_reset();
    #1;
    chk("rst_done",   {31'b0, done},      32'd0);
    chk("rst_passed", {31'b0, passed},    32'd0);
    chk("rst_tmo",    {31'b0, timed_out}, 32'd0);
    chk("rst_fail",   fail_count,         32'd0);
    chk("rst_rvalid", {31'b0, bus_rvalid},32'd0);
    chk("rst_rdata",  bus_rdata,          32'd0);
    cyc(10);
    bus_write(4'h0, 32'h1);
    chk("t1_done_lag", {31'b0, done}, 32'd0);
    cyc();
    chk("t1_done",   {31'b0, done},   32'd1);
    chk("t1_passed", {31'b0, passed}, 32'd1);
    chk("t1_fail",   fail_count,      32'd0);
    bus_read_chk("t1_status", 4'h0, 32'h6);
    cyc();
    chk("t1_rvalid_low", {31'b0, bus_rvalid}, 32'd0);

    // ---- 2: three failures then finish ----
    do_reset();
    bus_write(4'h0, 32'h2);
    bus_write(4'h0, 32'h2);
    bus_write(4'h0, 32'h2);
    chk("t2_fail3", fail_count, 32'd3);
    bus_write(4'h0, 32'h1);
    cyc();
    chk("t2_done",   {31'b0, done},   32'd1);
    chk("t2_passed", {31'b0, passed}, 32'd0);
    bus_read_chk("t2_status", 4'h0, 32'h2);
    bus_read_chk("t2_failcnt", 4'h4, 32'd3);

    // ---- 3: watchdog ----
    do_reset();
    cyc(2);                       // cycle_cnt = 2
    bus_write(4'hC, 32'd20);      // cycle_cnt = 3
    cyc(16);                      // cycle_cnt = 19
    chk("t3_done_early", {31'b0, done}, 32'd0);
    cyc();                        // cycle_cnt = 20, state TIMEOUT
    chk("t3_done_lag", {31'b0, done}, 32'd0);
    cyc();
    chk("t3_done", {31'b0, done},      32'd1);
    chk("t3_tmo",  {31'b0, timed_out}, 32'd1);
    chk("t3_pass", {31'b0, passed},    32'd0);
    bus_read_chk("t3_cycle_a", 4'h8, 32'd20);
    cyc(5);
    bus_read_chk("t3_cycle_b", 4'h8, 32'd20);
    bus_read_chk("t3_status", 4'h0, 32'hA);

    // ---- 4: FAIL_INC and FINISH together ----
    do_reset();
    cyc(3);
    bus_write(4'h0, 32'h3);
    chk("t4_fail1", fail_count, 32'd1);
    cyc();
    chk("t4_done",   {31'b0, done},   32'd1);
    chk("t4_passed", {31'b0, passed}, 32'd0);
    bus_write(4'h0, 32'h2);
    chk("t4_inc_ignored", fail_count, 32'd1);
    bus_write(4'h4, 32'h0);
    chk("t4_clr_ignored", fail_count, 32'd1);
    bus_write(4'hC, 32'd5);
    bus_read_chk("t4_tmo_ignored", 4'hC, 32'd100000);
    bus_read_chk("t4_status", 4'h0, 32'h2);

    // ---- 5: FINISH on the timeout cycle ----
    do_reset();
    bus_write(4'hC, 32'd8);       // cycle_cnt = 1
    cyc(6);                       // cycle_cnt = 7
    bus_write(4'h0, 32'h1);       // cycle_cnt+1 == timeout, FINISH wins
    cyc();
    chk("t5_done",   {31'b0, done},      32'd1);
    chk("t5_passed", {31'b0, passed},    32'd1);
    chk("t5_tmo",    {31'b0, timed_out}, 32'd0);

    // ---- 5b: FAIL_CNT clear and late TIMEOUT write during RUN ----
    do_reset();
    bus_write(4'h0, 32'h2);
    bus_write(4'h0, 32'h2);
    chk("t5b_fail2", fail_count, 32'd2);
    bus_write(4'h4, 32'hFFFF_FFFF);
    chk("t5b_clr", fail_count, 32'd0);
    cyc(3);                       // cycle_cnt = 6
    bus_write(4'hC, 32'd4);       // cycle_cnt = 7, timeout below count
    cyc();                        // state TIMEOUT
    cyc();
    chk("t5b_tmo", {31'b0, timed_out}, 32'd1);
    bus_read_chk("t5b_cycle", 4'h8, 32'd8);

    // ---- 6: async reset mid-run with read in flight ----
    do_reset();
    bus_write(4'h0, 32'h3);
    cyc();
    chk("t6_pre_done", {31'b0, done}, 32'd1);
    bus_en = 1'b1; bus_we = 1'b0; bus_addr = 4'h4;
    cyc();
    bus_en = 1'b0;
    chk("t6_pre_rvalid", {31'b0, bus_rvalid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_rvalid", {31'b0, bus_rvalid}, 32'd0);
    chk("t6_rst_done",   {31'b0, done},       32'd0);
    chk("t6_rst_passed", {31'b0, passed},     32'd0);
    chk("t6_rst_tmo",    {31'b0, timed_out},  32'd0);
    chk("t6_rst_fail",   fail_count,          32'd0);
    chk("t6_rst_rdata",  bus_rdata,           32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus_read_chk("t6_cycle0", 4'h8, 32'd0);
    bus_read_chk("t6_timeout", 4'hC, 32'd100000);
    bus_read_chk("t6_status_run", 4'h0, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
